// File: rtl/wb_stream_pkg.sv
// Shared types and constants for the Wishbone streaming readers.
package wb_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StPause
    } rd_state_t;

    localparam logic [3:0]  WB_SEL_ALL    = 4'hF;
    localparam int unsigned WB_WORD_BYTES = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with flush; push and pop may coincide at any level.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (cnt_q != '0);
        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        push_ok  = push && ((cnt_q != LW'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d = cnt_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == LW'(DEPTH));
    assign level = cnt_q;

endmodule

// File: rtl/wb_stream_reader.sv
// Wishbone classic read master streaming a linear block of words into a show-ahead FIFO.
module wb_stream_reader
    import wb_stream_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_W      = 20,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             wb_m_cyc,
    output logic             wb_m_stb,
    output logic             wb_m_we,
    output logic [3:0]       wb_m_sel,
    output logic [31:0]      wb_m_adr,
    output logic [31:0]      wb_m_dat_ms,
    input  logic [31:0]      wb_m_dat_sm,
    input  logic             wb_m_ack,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [LEN_W-1:0] nb_words,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic             rd_en,
    output logic [31:0]      rd_data,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    rd_state_t        state_q, state_d;
    logic             cyc_q, cyc_d;
    logic [31:0]      adr_q, adr_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             done_q, done_d;
    logic             push, flush, pop_eff;
    logic             fifo_full;

    assign pop_eff = rd_en && !empty;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        adr_d    = adr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;
        if (abort) begin
            state_d = StIdle;
            cyc_d   = 1'b0;
            flush   = 1'b1;
            done_d  = (state_q != StIdle);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (nb_words != '0) begin
                            adr_d    = base_adr & ~32'h3;
                            remain_d = nb_words;
                            cyc_d    = 1'b1;
                            state_d  = StReq;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (wb_m_ack) begin
                        push     = 1'b1;
                        adr_d    = adr_q + 32'(WB_WORD_BYTES);
                        remain_d = remain_q - LEN_W'(1);
                        if (remain_q == LEN_W'(1)) begin
                            cyc_d   = 1'b0;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else if (level >= LVL_W'(FIFO_DEPTH - 1) && !pop_eff) begin
                            // This push fills the last slot: no room for the next word.
                            cyc_d   = 1'b0;
                            state_d = StPause;
                        end
                    end
                end
                StPause: begin
                    if (!fifo_full) begin
                        cyc_d   = 1'b1;
                        state_d = StReq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cyc_q    <= 1'b0;
            adr_q    <= '0;
            remain_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
            remain_q <= remain_d;
            done_q   <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_en),
        .flush (flush),
        .din   (wb_m_dat_sm),
        .dout  (rd_data),
        .empty (empty),
        .full  (fifo_full),
        .level (level)
    );

    assign wb_m_cyc    = cyc_q;
    assign wb_m_stb    = cyc_q;
    assign wb_m_we     = 1'b0;
    assign wb_m_sel    = WB_SEL_ALL;
    assign wb_m_adr    = adr_q;
    assign wb_m_dat_ms = '0;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;

endmodule
